// File: rtl/loader_seq_pkg.sv
// loader_seq_pkg: shared types and widths for the loader sequencer
package loader_seq_pkg;
  localparam int ID_W = 5;
  localparam int AXLEN_W = 8;
  localparam int ROUND_W = 16;
  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT_ACK,
    S_WAIT_IDLE,
    S_DONE
  } seq_state_e;
  typedef struct packed {
    logic [ID_W-1:0]    id;
    logic               write;
    logic [AXLEN_W-1:0] axlen;
  } loader_desc_t;
endpackage

// File: rtl/loader_seq_prog_mem.sv
// loader_seq_prog_mem: descriptor program register file, sync write, comb read
// ports: clk, we/waddr/wdata write port, raddr/rdata read port
module loader_seq_prog_mem
  import loader_seq_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  loader_desc_t             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output loader_desc_t             rdata
);
  loader_desc_t mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/axi_loader_sequencer.sv
// axi_loader_sequencer: runs rounds of a descriptor program through one axi_master_loader
// ports: clk_i/rst_i; prog_* program write; num_desc_i/rounds_i/req_depth_cfg_i/run_i/stop_i control;
// req_depth_o/id_o/write_o/axlen_o/fifo_push_o/start_o/idle_i loader side; busy_o/done_o/round_cnt_o/error_o status
module axi_loader_sequencer
  import loader_seq_pkg::*;
#(
  parameter int ID_WIDTH    = 5,
  parameter int AXLEN_WIDTH = 8,
  parameter int DEPTH_WIDTH = 8,
  parameter int PROG_DEPTH  = 16,
  parameter int FIFO_DEPTH  = 32,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          prog_we_i,
  input  logic [$clog2(PROG_DEPTH)-1:0] prog_addr_i,
  input  logic [ID_WIDTH-1:0]           prog_id_i,
  input  logic                          prog_write_i,
  input  logic [AXLEN_WIDTH-1:0]        prog_axlen_i,
  input  logic [$clog2(PROG_DEPTH):0]   num_desc_i,
  input  logic [15:0]                   rounds_i,
  input  logic [DEPTH_WIDTH-1:0]        req_depth_cfg_i,
  input  logic                          run_i,
  input  logic                          stop_i,
  output logic [DEPTH_WIDTH-1:0]        req_depth_o,
  output logic [ID_WIDTH-1:0]           id_o,
  output logic                          write_o,
  output logic [AXLEN_WIDTH-1:0]        axlen_o,
  output logic                          fifo_push_o,
  output logic                          start_o,
  input  logic                          idle_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic [15:0]                   round_cnt_o,
  output logic                          error_o
);
  localparam int AW = $clog2(PROG_DEPTH);
  localparam int NW = AW + 1;
  localparam int MAX_DESC = PROG_DEPTH < FIFO_DEPTH ? PROG_DEPTH : FIFO_DEPTH;
  localparam int TW = $clog2(ACK_TIMEOUT) + 1;
  seq_state_e          state;
  logic [NW-1:0]       n_q;
  logic [NW-1:0]       idx;
  logic [ROUND_W-1:0]  rounds_q;
  logic [TW-1:0]       timer;
  logic                stop_q;
  logic                legal;
  loader_desc_t        wdata;
  loader_desc_t        rd;
  assign legal = (num_desc_i != '0) && (int'(num_desc_i) <= MAX_DESC);
  assign wdata = '{id: ID_W'(prog_id_i), write: prog_write_i, axlen: AXLEN_W'(prog_axlen_i)};
  // idx sits at 0 outside LOAD, so the slot-0 descriptor is already on rd when a round begins
  loader_seq_prog_mem #(.DEPTH(PROG_DEPTH)) u_mem (
    .clk   (clk_i),
    .we    (prog_we_i && state == S_IDLE),
    .waddr (prog_addr_i),
    .wdata (wdata),
    .raddr (idx[AW-1:0]),
    .rdata (rd)
  );
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= S_IDLE;
      n_q         <= '0;
      idx         <= '0;
      rounds_q    <= '0;
      timer       <= '0;
      stop_q      <= 1'b0;
      req_depth_o <= '0;
      id_o        <= '0;
      write_o     <= 1'b0;
      axlen_o     <= '0;
      fifo_push_o <= 1'b0;
      start_o     <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      round_cnt_o <= '0;
      error_o     <= 1'b0;
    end else begin
      if (state != S_IDLE && stop_i) stop_q <= 1'b1;
      case (state)
        S_IDLE:
          if (run_i && idle_i) begin
            if (legal) begin
              n_q         <= num_desc_i;
              rounds_q    <= rounds_i;
              req_depth_o <= req_depth_cfg_i;
              round_cnt_o <= '0;
              error_o     <= 1'b0;
              stop_q      <= 1'b0;
              busy_o      <= 1'b1;
              fifo_push_o <= 1'b1;
              id_o        <= ID_WIDTH'(rd.id);
              write_o     <= rd.write;
              axlen_o     <= AXLEN_WIDTH'(rd.axlen);
              idx         <= NW'(1);
              state       <= S_LOAD;
            end else error_o <= 1'b1;
          end
        S_LOAD:
          if (idx == n_q) begin
            fifo_push_o <= 1'b0;
            id_o        <= '0;
            write_o     <= 1'b0;
            axlen_o     <= '0;
            idx         <= '0;
            start_o     <= 1'b1;
            state       <= S_START;
          end else begin
            id_o    <= ID_WIDTH'(rd.id);
            write_o <= rd.write;
            axlen_o <= AXLEN_WIDTH'(rd.axlen);
            idx     <= idx + 1'b1;
          end
        S_START: begin
          start_o <= 1'b0;
          timer   <= '0;
          state   <= S_WAIT_ACK;
        end
        S_WAIT_ACK:
          if (!idle_i) state <= S_WAIT_IDLE;
          else if (timer == TW'(ACK_TIMEOUT - 1)) begin
            error_o <= 1'b1;
            done_o  <= 1'b1;
            state   <= S_DONE;
          end else timer <= timer + 1'b1;
        S_WAIT_IDLE:
          if (idle_i) begin
            round_cnt_o <= round_cnt_o + 1'b1;
            if (stop_q || (rounds_q != '0 && round_cnt_o + 1'b1 == rounds_q)) begin
              done_o <= 1'b1;
              state  <= S_DONE;
            end else begin
              fifo_push_o <= 1'b1;
              id_o        <= ID_WIDTH'(rd.id);
              write_o     <= rd.write;
              axlen_o     <= AXLEN_WIDTH'(rd.axlen);
              idx         <= NW'(1);
              state       <= S_LOAD;
            end
          end
        S_DONE: begin
          done_o <= 1'b0;
          busy_o <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_loader_sequencer.sv
// tb_axi_loader_sequencer: directed/randomized self-checking bench with a loader handshake model
module tb_axi_loader_sequencer;
  localparam int ACK_TIMEOUT = 64;
  logic        clk = 1'b0;
  logic        rst_i, prog_we_i, prog_write_i, run_i, stop_i, idle_i;
  logic [3:0]  prog_addr_i;
  logic [4:0]  prog_id_i;
  logic [7:0]  prog_axlen_i;
  logic [4:0]  num_desc_i;
  logic [15:0] rounds_i;
  logic [7:0]  req_depth_cfg_i;
  logic [7:0]  req_depth_o;
  logic [4:0]  id_o;
  logic        write_o, fifo_push_o, start_o, busy_o, done_o, error_o;
  logic [7:0]  axlen_o;
  logic [15:0] round_cnt_o;
  logic [4:0]  ref_id [16];
  logic        ref_wr [16];
  logic [7:0]  ref_len [16];
  int checks = 0;
  int errors = 0;

  axi_loader_sequencer dut (
    .clk_i(clk), .rst_i(rst_i), .prog_we_i(prog_we_i), .prog_addr_i(prog_addr_i),
    .prog_id_i(prog_id_i), .prog_write_i(prog_write_i), .prog_axlen_i(prog_axlen_i),
    .num_desc_i(num_desc_i), .rounds_i(rounds_i), .req_depth_cfg_i(req_depth_cfg_i),
    .run_i(run_i), .stop_i(stop_i), .req_depth_o(req_depth_o), .id_o(id_o),
    .write_o(write_o), .axlen_o(axlen_o), .fifo_push_o(fifo_push_o), .start_o(start_o),
    .idle_i(idle_i), .busy_o(busy_o), .done_o(done_o), .round_cnt_o(round_cnt_o),
    .error_o(error_o)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return {21'd0, req_depth_o, id_o, write_o, axlen_o, fifo_push_o, start_o,
            busy_o, done_o, round_cnt_o, error_o};
  endfunction

  task automatic wr(input int a, input int id, input bit w, input int len);
    prog_we_i = 1'b1;
    prog_addr_i = a[3:0];
    prog_id_i = id[4:0];
    prog_write_i = w;
    prog_axlen_i = len[7:0];
    tick;
    prog_we_i = 1'b0;
    ref_id[a] = id[4:0];
    ref_wr[a] = w;
    ref_len[a] = len[7:0];
  endtask

  // One full sequence: every round must push slots 0..n-1 then pulse start; the loader model
  // acknowledges after a random delay, stays busy a random time, then returns to idle.
  task automatic run_seq(input int n, input int rounds, input int stop_round);
    logic [7:0] cfg;
    bit fin;
    int d, l;
    cfg = 8'($urandom_range(0, 255));
    num_desc_i = 5'(n);
    rounds_i = 16'(rounds);
    req_depth_cfg_i = cfg;
    run_i = 1'b1;
    tick;
    run_i = 1'b0;
    chk("busy_start", busy_o, 1);
    chk("req_depth", req_depth_o, cfg);
    chk("err_clear", error_o, 0);
    fin = 1'b0;
    for (int r = 1; r <= 50 && !fin; r++) begin
      for (int k = 0; k < n; k++) begin
        chk("push", {fifo_push_o, start_o}, 2'b10);
        chk("desc", {id_o, write_o, axlen_o}, {ref_id[k], ref_wr[k], ref_len[k]});
        tick;
      end
      chk("start", {fifo_push_o, start_o, id_o, write_o, axlen_o}, {2'b01, 14'd0});
      tick;
      d = $urandom_range(0, 3);
      l = (r == stop_round) ? $urandom_range(2, 5) : $urandom_range(1, 5);
      for (int j = 0; j < d; j++) begin
        chk("wait_ack", {fifo_push_o, start_o, busy_o}, 3'b001);
        tick;
      end
      idle_i = 1'b0;
      for (int j = 0; j < l; j++) begin
        if (r == stop_round && j == 1) stop_i = 1'b1;
        tick;
        stop_i = 1'b0;
        chk("wait_idle", {fifo_push_o, start_o, busy_o, done_o}, 4'b0010);
      end
      idle_i = 1'b1;
      tick;
      chk("round_cnt", round_cnt_o, r);
      fin = (rounds != 0 && r == rounds) || r == stop_round;
      chk("done", done_o, fin);
      if (fin) begin
        tick;
        chk("end", {busy_o, done_o, fifo_push_o}, 0);
      end
    end
    if (!fin) chk("finish_bound", fin, 1);
  endtask

  initial begin
    int got;
    rst_i = 1'b1; prog_we_i = 0; prog_addr_i = 0; prog_id_i = 0; prog_write_i = 0;
    prog_axlen_i = 0; num_desc_i = 0; rounds_i = 0; req_depth_cfg_i = 0;
    run_i = 0; stop_i = 0; idle_i = 1'b1;
    tick;
    tick;
    rst_i = 1'b0;
    chk("reset_outs", outs(), 0);
    // single round, fixed program
    wr(0, 1, 1'b1, 3);
    wr(1, 2, 1'b0, 0);
    wr(2, 3, 1'b1, 7);
    run_seq(3, 1, 0);
    // multi-round with a random program
    for (int a = 0; a < 16; a++) wr(a, $urandom_range(0, 31), 1'($urandom_range(0, 1)), $urandom_range(0, 255));
    run_seq(2, 4, 0);
    // run forever, stop requested during round 3
    run_seq($urandom_range(1, 16), 0, 3);
    repeat (8) begin
      tick;
      chk("quiet_after_stop", {fifo_push_o, start_o, busy_o}, 0);
    end
    // illegal descriptor counts and run while the loader is busy
    num_desc_i = 5'd0; run_i = 1'b1; tick; run_i = 1'b0;
    chk("illegal0_err", error_o, 1);
    chk("illegal0_quiet", {busy_o, fifo_push_o}, 0);
    tick;
    chk("illegal0_busy", {busy_o, fifo_push_o}, 0);
    num_desc_i = 5'd17; run_i = 1'b1; tick; run_i = 1'b0;
    chk("illegal17", {error_o, busy_o, fifo_push_o}, 3'b100);
    num_desc_i = 5'd2; idle_i = 1'b0; run_i = 1'b1; tick; run_i = 1'b0; idle_i = 1'b1;
    chk("run_not_idle", {error_o, busy_o, fifo_push_o}, 3'b100);
    // ack timeout: loader never leaves idle
    num_desc_i = 5'd1; rounds_i = 16'd1; run_i = 1'b1; tick; run_i = 1'b0;
    chk("to_push", {fifo_push_o, id_o, write_o, axlen_o}, {1'b1, ref_id[0], ref_wr[0], ref_len[0]});
    tick;
    chk("to_start", start_o, 1);
    got = -1;
    for (int c = 1; c <= 200; c++) begin
      tick;
      if (done_o) begin
        got = c;
        break;
      end
    end
    chk("timeout_cycles", got, ACK_TIMEOUT + 1);
    chk("timeout_err", {error_o, round_cnt_o}, {1'b1, 16'd0});
    tick;
    chk("timeout_idle", {busy_o, done_o}, 0);
    // writes during a run are ignored; reset in the second push cycle aborts
    num_desc_i = 5'd4; rounds_i = 16'd1; run_i = 1'b1; tick; run_i = 1'b0;
    chk("rst_push0", {fifo_push_o, id_o}, {1'b1, ref_id[0]});
    prog_we_i = 1'b1; prog_addr_i = 4'd0; prog_id_i = ~ref_id[0];
    prog_write_i = ~ref_wr[0]; prog_axlen_i = ~ref_len[0];
    tick;
    prog_we_i = 1'b0;
    chk("rst_push1", {fifo_push_o, id_o, write_o, axlen_o}, {1'b1, ref_id[1], ref_wr[1], ref_len[1]});
    rst_i = 1'b1;
    tick;
    rst_i = 1'b0;
    chk("reset_mid_load", outs(), 0);
    run_seq(3, 1, 0);
    // full program depth
    run_seq(16, 2, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/axi_loader_sequencer.md
Name: axi_loader_sequencer

Overview:
Controller that sequences one axi_master_loader through repeated traffic rounds. It holds a small descriptor program (id, write, axlen), pushes the descriptors into the loader's command FIFO, pulses start, and waits for the loader to drain. It repeats for a configured number of rounds and reports status. It sits between the test/PMU control logic and the loader's command/start/idle interface inside the NoC traffic-generation harness.

Parameters:
ID_WIDTH, 5, width of descriptor AXI ID
AXLEN_WIDTH, 8, width of descriptor burst length
DEPTH_WIDTH, 8, width of req_depth passed to loader
PROG_DEPTH, 16, number of descriptor slots; power of two, <= FIFO_DEPTH
FIFO_DEPTH, 32, loader command FIFO depth; used for num_desc range check
ACK_TIMEOUT, 64, max cycles after start_o to see idle_i fall

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
prog_we_i  in  1  descriptor write strobe
prog_addr_i  in  $clog2(PROG_DEPTH)  descriptor slot
prog_id_i  in  ID_WIDTH  descriptor ID
prog_write_i  in  1  descriptor direction (1 = write)
prog_axlen_i  in  AXLEN_WIDTH  descriptor burst length
num_desc_i  in  $clog2(PROG_DEPTH)+1  descriptors per round
rounds_i  in  16  round count; 0 = run until stop
req_depth_cfg_i  in  DEPTH_WIDTH  outstanding-request depth for loader
run_i  in  1  start-sequence pulse
stop_i  in  1  graceful stop request
req_depth_o  out  DEPTH_WIDTH  to loader req_depth_i
id_o  out  ID_WIDTH  to loader id_i
write_o  out  1  to loader write_i
axlen_o  out  AXLEN_WIDTH  to loader axlen_i
fifo_push_o  out  1  to loader fifo_push_i
start_o  out  1  to loader start_i
idle_i  in  1  from loader idle_o
busy_o  out  1  sequence in progress
done_o  out  1  one-cycle pulse at sequence completion
round_cnt_o  out  16  completed rounds in the current sequence
error_o  out  1  sticky error flag

Behaviour:
- Reset (rst_i=1 at a clock edge): state IDLE. All outputs 0. Program memory contents are not reset. Stop latch cleared. Reset mid-run aborts immediately; the loader is reset by its own reset.
- States: IDLE, LOAD, START, WAIT_ACK, WAIT_IDLE, DONE.
- IDLE: prog_we_i writes the slot. run_i with idle_i=1 and 1 <= num_desc_i <= min(PROG_DEPTH, FIFO_DEPTH) does the following:
  - latches num_desc_i, rounds_i and req_depth_cfg_i (req_depth_o holds it until the next run);
  - clears round_cnt_o and error_o;
  - goes to LOAD.
- run_i with an illegal num_desc_i sets error_o and stays in IDLE. run_i with idle_i=0 is ignored.
- LOAD: one descriptor per cycle, slot index 0..n-1. fifo_push_o=1 with id_o/write_o/axlen_o registered from the slot. There are exactly n push cycles, then START.
  - Example: run_i sampled at edge N gives pushes in cycles N+1..N+n and start_o in cycle N+n+1.
- START: start_o=1 for exactly one cycle, then WAIT_ACK.
- WAIT_ACK: wait for idle_i=0, then go to WAIT_IDLE. If ACK_TIMEOUT cycles elapse first, set error_o and go to DONE.
- WAIT_IDLE: on idle_i=1, round_cnt_o increments (wraps mod 2^16). Then:
  - if stop is latched, or rounds_i != 0 and the new count equals rounds_i, go to DONE;
  - otherwise go to LOAD (next round, same program).
- DONE: done_o=1 for one cycle, then IDLE.
- busy_o=1 in every state except IDLE.
- stop_i in any non-IDLE state sets the stop latch. The current round always completes because the loader cannot abort a burst. stop_i in IDLE is ignored.
- prog_we_i outside IDLE is ignored; the program is stable during a run.
- run_i while busy is ignored.
- fifo_push_o and start_o are never high in the same cycle.
- id_o/write_o/axlen_o are 0 when fifo_push_o=0.

Decomposition:
- Package loader_seq_pkg:
  - state enum seq_state_e;
  - packed struct loader_desc_t {id, write, axlen}, parameterised via package localparams matching the defaults;
  - localparam ROUND_W=16.
- Sub-module loader_seq_prog_mem: PROG_DEPTH x loader_desc_t register file, 1 synchronous write port and 1 combinational read port.
- The FSM and counters live in the top module.

Test Plan:
- Single round: program slots 0..2 = {id 1,W,len 3},{id 2,R,len 0},{id 3,W,len 7}; num_desc=3, rounds=1, run at edge N.
  - Response: pushes in N+1..N+3 with exact fields; start_o at N+4; after loader idle falls then rises, round_cnt_o=1, done_o one pulse, busy_o=0.
- Multi-round: rounds=4, num_desc=2. Response: 4 push/start groups, round_cnt_o steps 1..4, a single done_o.
- Graceful stop: rounds=0; assert stop_i during round 3's WAIT_IDLE. Response: round 3 completes, round_cnt_o=3, no 4th push group, done_o.
- Illegal config: run with num_desc=0, then with num_desc=17. Response: error_o=1, busy_o stays 0, no fifo_push_o.
- Ack timeout: idle_i held at 1 after start_o. Response: after 64 cycles error_o=1, done_o pulse, IDLE.
- Reset mid-LOAD plus ignored writes: prog_we_i during a run leaves slot contents unchanged; rst_i in the 2nd push cycle gives all outputs 0 on the next cycle and state IDLE.
